ram_burst_bridge: RTL and testbench

//  Single-clock cache-line <-> RAM-word burst bridge; successor to the dual-clock cache/RAM interface.

---
 rtl/ram_burst_bridge.sv | 141 ++++++++++++++
 tb/tb_ram_burst_bridge.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_burst_bridge.sv
// rtl/ram_burst_bridge.sv - single-clock cache-line <-> RAM-word burst bridge, one beat in flight
// Optional build macro RAM_BRIDGE_TIMEOUT_EN adds a per-beat ram_ack timeout that reports via cache_err.
module ram_burst_bridge #(
  parameter int ADDR_SIZE      = 13,
  parameter int LINE_WIDTH     = 64,
  parameter int WORD_SIZE      = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cache_avalid,
  input  logic                  cache_rnw,
  input  logic [ADDR_SIZE-1:0]  cache_addr,
  input  logic [LINE_WIDTH-1:0] cache_wdata,
  output logic [LINE_WIDTH-1:0] cache_rdata,
  output logic                  cache_ack,
  output logic                  cache_err,
  output logic                  cache_busy,
  output logic [ADDR_SIZE-1:0]  ram_addr,
  output logic [WORD_SIZE-1:0]  ram_wdata,
  output logic                  ram_avalid,
  output logic                  ram_rnw,
  input  logic [WORD_SIZE-1:0]  ram_rdata,
  input  logic                  ram_ack
);

  localparam int WORDS = LINE_WIDTH / WORD_SIZE;
  localparam int IDX_W = $clog2(WORDS);

  typedef enum logic [1:0] {S_IDLE, S_BEAT, S_DONE} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [IDX_W-1:0]      r_idx;
  logic [ADDR_SIZE-1:0]  r_base;
  logic                  r_rnw;
  logic [LINE_WIDTH-1:0] r_wline;
  logic [LINE_WIDTH-1:0] r_rline;
  logic [LINE_WIDTH-1:0] r_rdata;
  logic [LINE_WIDTH-1:0] w_rline_upd;
  logic                  w_accept;
  logic                  w_beat_ack;
  logic                  w_last;
  logic                  w_timeout;

  assign w_accept   = (r_state == S_IDLE) && cache_avalid;
  assign w_beat_ack = (r_state == S_BEAT) && ram_ack;
  assign w_last     = (r_idx == IDX_W'(WORDS - 1));

`ifdef RAM_BRIDGE_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WAIT_W-1:0] r_wait;
  logic              r_err;

  // Counts cycles the current beat has been waiting; fires on the cycle it would reach the limit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wait <= '0;
    end else if (w_accept || w_beat_ack) begin
      r_wait <= '0;
    end else if (r_state == S_BEAT) begin
      r_wait <= r_wait + 1'b1;
    end
  end

  assign w_timeout = (r_state == S_BEAT) && !ram_ack && (r_wait == WAIT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (r_state == S_BEAT) begin
      r_err <= w_timeout;
    end
  end

  assign cache_err = r_err && (r_state == S_DONE);
`else
  // Never fires; TIMEOUT_CYCLES only matters in the timeout build.
  assign w_timeout = (TIMEOUT_CYCLES < 0);
  assign cache_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (cache_avalid) w_next = S_BEAT;
      S_BEAT:  if ((w_beat_ack && w_last) || w_timeout) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_rline_upd = r_rline;
    w_rline_upd[r_idx*WORD_SIZE +: WORD_SIZE] = ram_rdata;
  end

  // The beat index holds at WORDS-1 after the last beat; only accept or reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx   <= '0;
      r_base  <= '0;
      r_rnw   <= 1'b0;
      r_wline <= '0;
      r_rline <= '0;
      r_rdata <= '0;
    end else if (w_accept) begin
      r_idx   <= '0;
      r_base  <= cache_addr & ~ADDR_SIZE'(WORDS - 1);
      r_rnw   <= cache_rnw;
      r_wline <= cache_wdata;
    end else if (w_beat_ack) begin
      if (r_rnw) begin
        r_rline <= w_rline_upd;
      end
      if (!w_last) begin
        r_idx <= r_idx + 1'b1;
      end else if (r_rnw) begin
        r_rdata <= w_rline_upd;
      end
    end
  end

  assign ram_avalid  = (r_state == S_BEAT);
  assign ram_addr    = r_base + ADDR_SIZE'(r_idx);
  assign ram_wdata   = r_wline[r_idx*WORD_SIZE +: WORD_SIZE];
  assign ram_rnw     = r_rnw;
  assign cache_ack   = (r_state == S_DONE);
  assign cache_busy  = (r_state != S_IDLE);
  assign cache_rdata = r_rdata;

endmodule

// File: tb/tb_ram_burst_bridge.sv
// tb/tb_ram_burst_bridge.sv - scoreboard bench for ram_burst_bridge
module tb_ram_burst_bridge;
  localparam int AW = 13;
  localparam int LW = 64;
  localparam int WS = 16;
  localparam int WORDS = 4;
`ifdef RAM_BRIDGE_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          cache_avalid;
  logic          cache_rnw;
  logic [AW-1:0] cache_addr;
  logic [LW-1:0] cache_wdata;
  logic [LW-1:0] cache_rdata;
  logic          cache_ack;
  logic          cache_err;
  logic          cache_busy;
  logic [AW-1:0] ram_addr;
  logic [WS-1:0] ram_wdata;
  logic          ram_avalid;
  logic          ram_rnw;
  logic [WS-1:0] ram_rdata;
  logic          ram_ack;

  always #5 clk = ~clk;

  ram_burst_bridge #(
    .ADDR_SIZE(AW), .LINE_WIDTH(LW), .WORD_SIZE(WS), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .cache_avalid(cache_avalid), .cache_rnw(cache_rnw), .cache_addr(cache_addr),
    .cache_wdata(cache_wdata), .cache_rdata(cache_rdata), .cache_ack(cache_ack),
    .cache_err(cache_err), .cache_busy(cache_busy),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_avalid(ram_avalid),
    .ram_rnw(ram_rnw), .ram_rdata(ram_rdata), .ram_ack(ram_ack)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [WS-1:0] wdata;
    logic          rnw;
  } beat_t;

  beat_t         exp_q[$];
  int            delay_q[$];
  logic [WS-1:0] rdq[$];
  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;
  bit            resp_en = 1'b0;
  bit            stray = 1'b0;
  int            wait_cnt = 0;
  logic [LW-1:0] last_rd;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: acks after the queued per-beat delay and checks each beat against the scoreboard.
  initial begin
    beat_t b;
    ram_ack = 1'b0;
    ram_rdata = '0;
    forever begin
      @(negedge clk);
      ram_ack = stray;
      if (resp_en && ram_avalid === 1'b1) begin
        if (delay_q.size() != 0 && wait_cnt < delay_q[0]) begin
          wait_cnt++;
          if (exp_q.size() != 0) begin
            checks++;
            if (ram_addr !== exp_q[0].addr) begin
              errors++;
              $display("FAIL stall_addr: got %h want %h", ram_addr, exp_q[0].addr);
            end
          end
        end else begin
          ram_ack = 1'b1;
          wait_cnt = 0;
          if (delay_q.size() != 0) void'(delay_q.pop_front());
          if (rdq.size() != 0) ram_rdata = rdq.pop_front();
          else ram_rdata = '0;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat: addr %h rnw %b, none expected", ram_addr, ram_rnw);
          end else begin
            b = exp_q.pop_front();
            if (ram_addr !== b.addr || ram_rnw !== b.rnw || (!b.rnw && ram_wdata !== b.wdata)) begin
              errors++;
              $display("FAIL beat: got addr %h rnw %b wdata %h want addr %h rnw %b wdata %h",
                       ram_addr, ram_rnw, ram_wdata, b.addr, b.rnw, b.wdata);
            end
          end
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic push_line(input logic rnw, input logic [AW-1:0] base, input logic [LW-1:0] wd);
    beat_t b;
    for (int i = 0; i < WORDS; i++) begin
      b.addr  = base + AW'(i);
      b.wdata = wd[i*WS +: WS];
      b.rnw   = rnw;
      exp_q.push_back(b);
    end
  endtask

  task automatic flush_q();
    exp_q.delete();
    delay_q.delete();
    rdq.delete();
  endtask

  task automatic run_xfer(input logic rnw, input logic [AW-1:0] addr, input logic [LW-1:0] wd,
                          output int lat, output logic [LW-1:0] rd, output logic err);
    int t0;
    bit ok;
    @(negedge clk);
    cache_avalid = 1'b1;
    cache_rnw    = rnw;
    cache_addr   = addr;
    cache_wdata  = wd;
    t0 = cyc;
    @(negedge clk);
    cache_avalid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (cache_ack === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    lat = cyc - t0;
    rd  = cache_rdata;
    err = cache_err;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: no cache_ack within 300 cycles of accept at %0d", t0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cache_avalid = 1'b0;
    cache_rnw = 1'b0;
    cache_addr = '0;
    cache_wdata = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({cache_rdata, cache_ack, cache_err, cache_busy, ram_addr, ram_wdata, ram_avalid, ram_rnw} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rdata %h ack %b err %b busy %b raddr %h rwdata %h ravalid %b rrnw %b, want all 0",
               cache_rdata, cache_ack, cache_err, cache_busy, ram_addr, ram_wdata, ram_avalid, ram_rnw);
    end
    reset = 1'b0;
    resp_en = 1'b1;
    last_rd = '0;
  endtask

  task automatic test_write();
    int lat;
    logic [LW-1:0] rd;
    logic err;
    push_line(1'b0, 13'h0104, 64'h4444_3333_2222_1111);
    run_xfer(1'b0, 13'h0105, 64'h4444_3333_2222_1111, lat, rd, err);
    checks++;
    if (lat !== WORDS + 1) begin errors++; $display("FAIL write_latency: got %0d want %0d", lat, WORDS + 1); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL write_err: got %b want 0", err); end
    checks++;
    if (rd !== last_rd) begin errors++; $display("FAIL write_rdata_held: got %h want %h", rd, last_rd); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL write_beats_left: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_read_stall();
    int lat;
    logic [LW-1:0] rd;
    logic err;
    push_line(1'b1, 13'h0200, '0);
    delay_q = '{0, 3, 1, 7};
    rdq = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
    run_xfer(1'b1, 13'h0200, 64'h0123_4567_89AB_CDEF, lat, rd, err);
    checks++;
    if (rd !== 64'hDDDD_CCCC_BBBB_AAAA) begin errors++; $display("FAIL read_rdata: got %h want DDDDCCCCBBBBAAAA", rd); end
    checks++;
    if (lat !== 16) begin errors++; $display("FAIL read_latency: got %0d want 16", lat); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL read_err: got %b want 0", err); end
    last_rd = 64'hDDDD_CCCC_BBBB_AAAA;
    flush_q();
  endtask

  task automatic test_wrap();
    int lat;
    logic [LW-1:0] rd;
    logic err;
    push_line(1'b0, 13'h1FFC, 64'h8888_7777_6666_5555);
    run_xfer(1'b0, 13'h1FFC, 64'h8888_7777_6666_5555, lat, rd, err);
    push_line(1'b0, 13'h1FFC, 64'hF00D_CAFE_BEEF_1234);
    run_xfer(1'b0, 13'h1FFE, 64'hF00D_CAFE_BEEF_1234, lat, rd, err);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_beats_left: got %0d want 0", exp_q.size()); end
    checks++;
    if (rd !== last_rd) begin errors++; $display("FAIL wrap_rdata_held: got %h want %h", rd, last_rd); end
  endtask

  task automatic test_back_to_back();
    int t0;
    int t1;
    bit ok;
    resp_en = 1'b0;
    stray = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (cache_busy !== 1'b0) begin errors++; $display("FAIL stray_ack_busy: got %b want 0", cache_busy); end
    end
    stray = 1'b0;
    resp_en = 1'b1;
    push_line(1'b0, 13'h0A00, 64'h1357_2468_ACE0_BDF1);
    push_line(1'b0, 13'h0A00, 64'h1357_2468_ACE0_BDF1);
    @(negedge clk);
    cache_avalid = 1'b1;
    cache_rnw = 1'b0;
    cache_addr = 13'h0A02;
    cache_wdata = 64'h1357_2468_ACE0_BDF1;
    t0 = cyc;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cache_ack === 1'b1) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok || cyc - t0 != WORDS + 1) begin
      errors++;
      $display("FAIL held_first_ack: got %0d cycles (seen %b) want %0d", cyc - t0, ok, WORDS + 1);
    end
    @(negedge clk);
    checks++;
    if (cache_busy !== 1'b0 || cache_ack !== 1'b0) begin
      errors++;
      $display("FAIL held_idle_visit: busy %b ack %b want 0 0", cache_busy, cache_ack);
    end
    t1 = cyc;
    @(negedge clk);
    checks++;
    if (cache_busy !== 1'b1) begin errors++; $display("FAIL held_reaccept: busy %b want 1", cache_busy); end
    cache_avalid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (cache_ack === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok || cyc - t1 != WORDS + 1) begin
      errors++;
      $display("FAIL held_second_ack: got %0d cycles (seen %b) want %0d", cyc - t1, ok, WORDS + 1);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || cache_busy !== 1'b0) begin
      errors++;
      $display("FAIL held_single_accept: beats left %0d busy %b want 0 0", exp_q.size(), cache_busy);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int acks;
    bit ok;
    logic [LW-1:0] rd;
    logic err;
    push_line(1'b1, 13'h0300, '0);
    delay_q = '{0, 0, 50, 0};
    rdq = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    @(negedge clk);
    cache_avalid = 1'b1;
    cache_rnw = 1'b1;
    cache_addr = 13'h0300;
    @(negedge clk);
    cache_avalid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ram_avalid === 1'b1 && ram_addr === 13'h0302) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL reset_mid_reach_beat2: got addr %h want 0302", ram_addr); end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({cache_rdata, cache_ack, cache_err, cache_busy, ram_addr, ram_wdata, ram_avalid, ram_rnw} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: rdata %h ack %b busy %b raddr %h ravalid %b rrnw %b, want all 0",
               cache_rdata, cache_ack, cache_busy, ram_addr, ram_avalid, ram_rnw);
    end
    reset = 1'b0;
    flush_q();
    acks = 0;
    repeat (10) begin
      @(negedge clk);
      if (cache_ack === 1'b1) acks++;
    end
    checks++;
    if (acks != 0) begin errors++; $display("FAIL reset_mid_no_ack: got %0d acks want 0", acks); end
    push_line(1'b1, 13'h0304, '0);
    rdq = '{16'h5A5A, 16'h6B6B, 16'h7C7C, 16'h8D8D};
    run_xfer(1'b1, 13'h0307, '0, lat, rd, err);
    checks++;
    if (rd !== 64'h8D8D_7C7C_6B6B_5A5A || lat !== WORDS + 1) begin
      errors++;
      $display("FAIL reset_mid_recover: got rdata %h lat %0d want 8D8D7C7C6B6B5A5A lat %0d", rd, lat, WORDS + 1);
    end
    last_rd = 64'h8D8D_7C7C_6B6B_5A5A;
    flush_q();
  endtask

`ifdef RAM_BRIDGE_TIMEOUT_EN
  task automatic test_timeout();
    int lat;
    logic [LW-1:0] rd;
    logic err;
    push_line(1'b1, 13'h0400, '0);
    delay_q = '{0, 1000};
    rdq = '{16'hEEEE};
    run_xfer(1'b1, 13'h0400, '0, lat, rd, err);
    checks++;
    if (lat !== 2 + TO) begin errors++; $display("FAIL timeout_latency: got %0d want %0d", lat, 2 + TO); end
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL timeout_err: got %b want 1", err); end
    checks++;
    if (rd !== last_rd) begin errors++; $display("FAIL timeout_rdata_held: got %h want %h", rd, last_rd); end
    flush_q();
    @(negedge clk);
    checks++;
    if (cache_err !== 1'b0 || cache_busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_return_idle: err %b busy %b want 0 0", cache_err, cache_busy);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read_stall();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
`ifdef RAM_BRIDGE_TIMEOUT_EN
    test_timeout();
`endif
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
